// File: rtl/mips_write_checker.sv
// Snoops the MIPS data-memory write bus and checks each store, in order, against
// a loadable table of expected (address, data) pairs; reports verdict, error details and counts.
module mips_write_checker #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tbl_we,
    input  logic [$clog2(DEPTH)-1:0] tbl_idx,
    input  logic [ADDR_W-1:0]        tbl_addr,
    input  logic [DATA_W-1:0]        tbl_data,
    input  logic [$clog2(DEPTH):0]   num_exp,
    input  logic                     filter,
    input  logic                     start,
    input  logic                     memwrite,
    input  logic [ADDR_W-1:0]        dataadr,
    input  logic [DATA_W-1:0]        writedata,
    output logic                     running,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timed_out,
    output logic [$clog2(DEPTH)-1:0] err_idx,
    output logic [DATA_W-1:0]        err_data,
    output logic [CNT_W-1:0]         wr_count,
    output logic [CNT_W-1:0]         cyc_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W:0] NUM_FULL = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W:0]    num_lat;
    logic              filter_lat;

    logic [ADDR_W-1:0] exp_addr [DEPTH];
    logic [DATA_W-1:0] exp_data [DEPTH];

    logic              addr_hit;
    logic              data_hit;
    logic              store_match;
    logic              store_bad;
    logic              last_entry;
    logic              wd_expire;
    logic [IDX_W:0]    num_eff;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        addr_hit    = (dataadr == exp_addr[ptr]);
        data_hit    = (writedata == exp_data[ptr]);
        store_match = memwrite && addr_hit && data_hit;
        // in filtered mode a store to a different address is simply skipped
        store_bad   = memwrite && !(addr_hit && data_hit) && (!filter_lat || addr_hit);
        last_entry  = ({1'b0, ptr} == (num_lat - 1'b1));
        wd_expire   = WD_EN && (cyc_count == WD_LAST);
        num_eff     = ((num_exp == '0) || (num_exp > NUM_FULL)) ? NUM_FULL : num_exp;
    end

    // Table has no reset so expected pairs survive a reset pulse.
    always_ff @(posedge clk) begin
        if (tbl_we && (state != S_RUN) && (int'(tbl_idx) < DEPTH)) begin
            exp_addr[tbl_idx] <= tbl_addr;
            exp_data[tbl_idx] <= tbl_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            num_lat    <= '0;
            filter_lat <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timed_out  <= 1'b0;
            err_idx    <= '0;
            err_data   <= '0;
            wr_count   <= '0;
            cyc_count  <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    cyc_count <= sat_inc(cyc_count);
                    if (memwrite) begin
                        wr_count <= sat_inc(wr_count);
                    end
                    // a deciding store on the final watchdog cycle outranks the timeout
                    if (store_match) begin
                        if (last_entry) begin
                            state   <= S_PASS;
                            running <= 1'b0;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end else if (store_bad) begin
                        state    <= S_FAIL;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        fail     <= 1'b1;
                        err_idx  <= ptr;
                        err_data <= writedata;
                    end else if (wd_expire) begin
                        state     <= S_FAIL;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        timed_out <= 1'b1;
                        err_idx   <= ptr;
                        err_data  <= '0;
                    end
                end
                default: begin
                    if (start) begin
                        state      <= S_RUN;
                        running    <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail       <= 1'b0;
                        timed_out  <= 1'b0;
                        err_idx    <= '0;
                        err_data   <= '0;
                        ptr        <= '0;
                        wr_count   <= '0;
                        cyc_count  <= '0;
                        num_lat    <= num_eff;
                        filter_lat <= filter;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_write_checker.sv
// Directed bench for mips_write_checker: strict/filtered runs, data errors,
// watchdog timing and priority, start/table-write gating, async reset mid-run.
module tb_mips_write_checker;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 8;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              tbl_we;
    logic [IDX_W-1:0]  tbl_idx;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_data;
    logic [IDX_W:0]    num_exp;
    logic              filter;
    logic              start;
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;
    logic              running;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timed_out;
    logic [IDX_W-1:0]  err_idx;
    logic [DATA_W-1:0] err_data;
    logic [CNT_W-1:0]  wr_count;
    logic [CNT_W-1:0]  cyc_count;

    int checks = 0;
    int passed = 0;

    mips_write_checker #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(16),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tbl_we   (tbl_we),
        .tbl_idx  (tbl_idx),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .num_exp  (num_exp),
        .filter   (filter),
        .start    (start),
        .memwrite (memwrite),
        .dataadr  (dataadr),
        .writedata(writedata),
        .running  (running),
        .done     (done),
        .pass     (pass),
        .fail     (fail),
        .timed_out(timed_out),
        .err_idx  (err_idx),
        .err_data (err_data),
        .wr_count (wr_count),
        .cyc_count(cyc_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [IDX_W-1:0] idx, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
        tbl_we = 1'b1; tbl_idx = idx; tbl_addr = a; tbl_data = d;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic arm(input logic [IDX_W:0] n, input logic f);
        num_exp = n; filter = f; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
        num_exp = '0; filter = 1'b0; start = 1'b0; memwrite = 1'b0;
        dataadr = '0; writedata = '0;
        #23;
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_cyc", cyc_count, 0);
        reset_n = 1'b1;
        tick();

        // T1 strict pass, store at RUN cycle 10
        load(0, 84, 7);
        arm(1, 1'b0);
        chk("t1_running", running, 1);
        ticks(10);
        store(84, 7);
        chk("t1_pass", pass, 1);
        chk("t1_done", done, 1);
        chk("t1_running_off", running, 0);
        chk("t1_wr", wr_count, 1);
        chk("t1_cyc", cyc_count, 11);
        ticks(3);
        chk("t1_cyc_hold", cyc_count, 11);

        // T2 strict fail; entry 1 written on the start edge
        load(0, 80, 1);
        tbl_we = 1'b1; tbl_idx = 1; tbl_addr = 84; tbl_data = 7;
        arm(2, 1'b0);
        tbl_we = 1'b0;
        chk("t2_pass_clr", pass, 0);
        store(80, 1);
        chk("t2_mid_running", running, 1);
        store(88, 5);
        chk("t2_fail", fail, 1);
        chk("t2_err_idx", err_idx, 1);
        chk("t2_err_data", err_data, 5);
        chk("t2_timed_out", timed_out, 0);
        chk("t2_wr", wr_count, 2);

        // T3 filtered pass; start and tbl_we during RUN must be ignored
        arm(2, 1'b1);
        chk("t3_err_clr", err_data, 0);
        store(80, 1);
        start = 1'b1; tbl_we = 1'b1; tbl_idx = 0; tbl_addr = 80; tbl_data = 99;
        store(96, 3);
        start = 1'b0; tbl_we = 1'b0;
        chk("t3_mid_running", running, 1);
        store(84, 7);
        chk("t3_pass", pass, 1);
        chk("t3_wr", wr_count, 3);
        chk("t3_cyc", cyc_count, 3);

        // T4 filtered data error
        arm(2, 1'b1);
        store(96, 3);
        store(80, 2);
        chk("t4_fail", fail, 1);
        chk("t4_err_idx", err_idx, 0);
        chk("t4_err_data", err_data, 2);
        chk("t4_timed_out", timed_out, 0);
        chk("t4_wr", wr_count, 2);

        // T5 watchdog after exactly 16 RUN cycles
        arm(2, 1'b0);
        ticks(15);
        chk("t5_before", running, 1);
        chk("t5_cyc15", cyc_count, 15);
        tick();
        chk("t5_fail", fail, 1);
        chk("t5_timed_out", timed_out, 1);
        chk("t5_err_idx", err_idx, 0);
        chk("t5_err_data", err_data, 0);
        chk("t5_cyc16", cyc_count, 16);
        // re-arm; completing store on the timeout cycle wins
        arm(1, 1'b0);
        chk("t5_rearm_running", running, 1);
        chk("t5_rearm_to_clr", timed_out, 0);
        chk("t5_rearm_cyc", cyc_count, 0);
        ticks(15);
        store(80, 1);
        chk("t5_prio_pass", pass, 1);
        chk("t5_prio_to", timed_out, 0);
        chk("t5_prio_cyc", cyc_count, 16);

        // T6 num_exp=0 means DEPTH entries, then async reset mid-RUN
        arm(0, 1'b0);
        store(80, 1);
        store(84, 7);
        chk("t6_full_running", running, 1);
        chk("t6_full_pass", pass, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_running", running, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_wr", wr_count, 0);
        chk("t6_rst_cyc", cyc_count, 0);
        #2 reset_n = 1'b1;
        tick();
        arm(1, 1'b0);
        store(80, 1);
        chk("t6_rerun_pass", pass, 1);
        chk("t6_rerun_wr", wr_count, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
